vga_sync_gen: RTL and testbench

VGA 640x480 timing generator: the coordinate-producing end of the pixel interface that the text/graphics generators consume. It divides the system clock into a pixel-rate enable and runs horizontal and vertical counters. It drives `pix_x`/`pix_y`, `hsync`/`vsync` and `video_on`, and returns the generator's RGB to the DAC pins with blanking applied. It sits between the board clock/reset and every `pix_x`/`pix_y` consumer in the display path.

---
 rtl/vga_timing_pkg.sv | 36 +++
 rtl/vga_axis_ctr.sv | 55 +++++
 rtl/vga_sync_gen.sv | 143 ++++++++++++++
 tb/tb_vga_sync_gen.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_timing_pkg                                                             |
// | Default 640x480 timing constants, axis-total derivation, shared rgb_t.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package vga_timing_pkg;

   typedef logic [2:0] rgb_t;

   localparam int CTR_W = 10;

   localparam int H_DISPLAY_DEF = 640;
   localparam int H_FRONT_DEF   = 16;
   localparam int H_SYNC_DEF    = 96;
   localparam int H_BACK_DEF    = 48;
   localparam int V_DISPLAY_DEF = 480;
   localparam int V_FRONT_DEF   = 10;
   localparam int V_SYNC_DEF    = 2;
   localparam int V_BACK_DEF    = 33;

   function automatic int axis_total(input int display, input int front,
                                     input int sync, input int back);
      return display + front + sync + back;
   endfunction

   function automatic int h_total_def();
      return axis_total(H_DISPLAY_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
   endfunction

   function automatic int v_total_def();
      return axis_total(V_DISPLAY_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);
   endfunction

endpackage : vga_timing_pkg
`default_nettype wire

// File: rtl/vga_axis_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_axis_ctr                                                               |
// | One timing axis: wrapping position counter with registered active-low sync.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vga_axis_ctr
   import vga_timing_pkg::*;
#(
   parameter int DISPLAY = H_DISPLAY_DEF,
   parameter int FRONT   = H_FRONT_DEF,
   parameter int SYNC    = H_SYNC_DEF,
   parameter int BACK    = H_BACK_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             inc,
   output logic [CTR_W-1:0] count,
   output logic             sync_n,
   output logic             wrap
);

   localparam int               c_TOTAL      = axis_total(DISPLAY, FRONT, SYNC, BACK);
   localparam logic [CTR_W-1:0] c_LAST       = CTR_W'(c_TOTAL - 1);
   localparam logic [CTR_W-1:0] c_SYNC_START = CTR_W'(DISPLAY + FRONT);
   localparam logic [CTR_W-1:0] c_SYNC_END   = CTR_W'(DISPLAY + FRONT + SYNC - 1);

   logic [CTR_W-1:0] count_q, count_d;
   logic             sync_n_q, sync_n_d;

   always_comb begin
      count_d = count_q;
      wrap    = inc && (count_q == c_LAST);
      if (inc) begin
         count_d = (count_q == c_LAST) ? '0 : count_q + CTR_W'(1);
      end
      // Decoded from the next count so the sync lines up with the count it describes.
      sync_n_d = !((count_d >= c_SYNC_START) && (count_d <= c_SYNC_END));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q  <= '0;
         sync_n_q <= 1'b1;
      end else begin
         count_q  <= count_d;
         sync_n_q <= sync_n_d;
      end
   end

   assign count  = count_q;
   assign sync_n = sync_n_q;

endmodule : vga_axis_ctr
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_sync_gen                                                               |
// | VGA timing generator: pixel divider, x/y counters, sync, blanking.         |
// | VGA_SYNC_RGB_REG_EN: registers rgb_out and delays sync by one pixel.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV   = 2,
   parameter int H_DISPLAY = H_DISPLAY_DEF,
   parameter int H_FRONT   = H_FRONT_DEF,
   parameter int H_SYNC    = H_SYNC_DEF,
   parameter int H_BACK    = H_BACK_DEF,
   parameter int V_DISPLAY = V_DISPLAY_DEF,
   parameter int V_FRONT   = V_FRONT_DEF,
   parameter int V_SYNC    = V_SYNC_DEF,
   parameter int V_BACK    = V_BACK_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  rgb_t             rgb_in,
   output logic [CTR_W-1:0] pix_x,
   output logic [CTR_W-1:0] pix_y,
   output logic             p_tick,
   output logic             video_on,
   output logic             hsync,
   output logic             vsync,
   output logic             frame_tick,
   output rgb_t             rgb_out
);

   localparam int               c_H_TOTAL  = axis_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
   localparam int               c_V_TOTAL  = axis_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
   localparam logic [CTR_W-1:0] c_H_LAST   = CTR_W'(c_H_TOTAL - 1);
   localparam logic [CTR_W-1:0] c_H_PENULT = CTR_W'(c_H_TOTAL - 2);
   localparam logic [CTR_W-1:0] c_V_LAST   = CTR_W'(c_V_TOTAL - 1);
   localparam logic [CTR_W-1:0] c_H_DISP   = CTR_W'(H_DISPLAY);
   localparam logic [CTR_W-1:0] c_V_DISP   = CTR_W'(V_DISPLAY);
   localparam logic [1:0]       c_DIV_LAST = 2'(CLK_DIV - 1);

   logic [1:0]       div_q, div_d;
   logic             p_tick_q, p_tick_d;
   logic             frame_tick_q, frame_tick_d;
   logic [CTR_W-1:0] h_count, v_count;
   logic             h_sync_n, v_sync_n;
   logic             h_wrap;
   logic             v_wrap_unused;

   vga_axis_ctr #(
      .DISPLAY (H_DISPLAY),
      .FRONT   (H_FRONT),
      .SYNC    (H_SYNC),
      .BACK    (H_BACK)
   ) u_h_ctr (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (p_tick_q),
      .count   (h_count),
      .sync_n  (h_sync_n),
      .wrap    (h_wrap)
   );

   vga_axis_ctr #(
      .DISPLAY (V_DISPLAY),
      .FRONT   (V_FRONT),
      .SYNC    (V_SYNC),
      .BACK    (V_BACK)
   ) u_v_ctr (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (h_wrap),
      .count   (v_count),
      .sync_n  (v_sync_n),
      .wrap    (v_wrap_unused)
   );

   always_comb begin
      div_d    = (div_q == c_DIV_LAST) ? 2'd0 : div_q + 2'd1;
      p_tick_d = (div_q == c_DIV_LAST);
      // The tick must coincide with the last pixel, so look at the counts after this edge.
      frame_tick_d = p_tick_d && (v_count == c_V_LAST) &&
                     (p_tick_q ? (h_count == c_H_PENULT) : (h_count == c_H_LAST));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_q        <= 2'd0;
         p_tick_q     <= 1'b0;
         frame_tick_q <= 1'b0;
      end else begin
         div_q        <= div_d;
         p_tick_q     <= p_tick_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign pix_x      = h_count;
   assign pix_y      = v_count;
   assign p_tick     = p_tick_q;
   assign frame_tick = frame_tick_q;
   assign video_on   = (h_count < c_H_DISP) && (v_count < c_V_DISP);

`ifdef VGA_SYNC_RGB_REG_EN
   rgb_t rgb_q, rgb_d;
   logic hsync_q, hsync_d;
   logic vsync_q, vsync_d;

   always_comb begin
      rgb_d   = rgb_q;
      hsync_d = hsync_q;
      vsync_d = vsync_q;
      if (p_tick_q) begin
         rgb_d   = video_on ? rgb_in : rgb_t'(0);
         hsync_d = h_sync_n;
         vsync_d = v_sync_n;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rgb_q   <= '0;
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
      end else begin
         rgb_q   <= rgb_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
      end
   end

   assign rgb_out = rgb_q;
   assign hsync   = hsync_q;
   assign vsync   = vsync_q;
`else
   assign rgb_out = video_on ? rgb_in : rgb_t'(0);
   assign hsync   = h_sync_n;
   assign vsync   = v_sync_n;
`endif

endmodule : vga_sync_gen
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vga_sync_gen                                                            |
// | Random-colour bench for vga_sync_gen on a reduced raster, arithmetic model.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_vga_sync_gen;

   localparam int D  = 2;
   localparam int HD = 16, HF = 2, HS = 4, HB = 3;
   localparam int VD = 10, VF = 2, VS = 2, VB = 3;
   localparam int HT = HD + HF + HS + HB;
   localparam int VT = VD + VF + VS + VB;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [2:0] rgb_in;
   logic [9:0] pix_x, pix_y;
   logic       p_tick, video_on, hsync, vsync, frame_tick;
   logic [2:0] rgb_out;

   int         checks = 0;
   int         failures = 0;
   int         t = 0;
   logic [2:0] model_rgb = 3'b0;
   int         frames_dut = 0, frames_exp = 0;
   int         hs_low = 0, vs_low = 0;
   bit         phase2 = 1'b0;

   always #5 clk = ~clk;

   vga_sync_gen #(
      .CLK_DIV   (D),
      .H_DISPLAY (HD), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
      .V_DISPLAY (VD), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .rgb_in     (rgb_in),
      .pix_x      (pix_x),
      .pix_y      (pix_y),
      .p_tick     (p_tick),
      .video_on   (video_on),
      .hsync      (hsync),
      .vsync      (vsync),
      .frame_tick (frame_tick),
      .rgb_out    (rgb_out)
   );

   // t = clock edges since reset release; pixels elapsed and tick phase follow from it.
   function automatic int pcount(input int tt);
      return (tt == 0) ? 0 : (tt - 1) / D;
   endfunction

   function automatic bit ptick_m(input int tt);
      return (tt > 0) && (tt % D == 0);
   endfunction

   function automatic bit vis(input int p);
      return ((p % HT) < HD) && (((p / HT) % VT) < VD);
   endfunction

   function automatic bit hs_m(input int p);
      int x;
      x = p % HT;
      return !((x >= HD + HF) && (x < HD + HF + HS));
   endfunction

   function automatic bit vs_m(input int p);
      int y;
      y = (p / HT) % VT;
      return !((y >= VD + VF) && (y < VD + VF + VS));
   endfunction

   function automatic bit ft_m(input int tt);
      int p;
      p = pcount(tt);
      return ptick_m(tt) && (p % HT == HT - 1) && ((p / HT) % VT == VT - 1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0d exp=%0d t=%0d", tag, got, exp, t);
      end
   endtask

   task automatic check_state();
      int p;
      p = pcount(t);
      chk("pix_x",      pix_x,      p % HT);
      chk("pix_y",      pix_y,      (p / HT) % VT);
      chk("p_tick",     p_tick,     ptick_m(t));
      chk("video_on",   video_on,   vis(p));
      chk("frame_tick", frame_tick, ft_m(t));
`ifdef VGA_SYNC_RGB_REG_EN
      chk("hsync",   hsync,   (p >= 1) ? hs_m(p - 1) : 1'b1);
      chk("vsync",   vsync,   (p >= 1) ? vs_m(p - 1) : 1'b1);
      chk("rgb_out", rgb_out, model_rgb);
`else
      chk("hsync",   hsync,   hs_m(p));
      chk("vsync",   vsync,   vs_m(p));
      chk("rgb_out", rgb_out, vis(p) ? rgb_in : 3'b000);
`endif
   endtask

   // One clk: update model on the rising edge, check on the falling edge, new colour.
   task automatic step();
      @(posedge clk);
      if (!reset_n) begin
         t = 0;
         model_rgb = 3'b0;
      end else begin
         if (ptick_m(t)) model_rgb = vis(pcount(t)) ? rgb_in : 3'b000;
         t++;
      end
      @(negedge clk);
      check_state();
      if (phase2 && frames_dut == 0) begin
         if (!hsync && pix_y == 10'd3) hs_low++;
         if (!vsync) vs_low++;
      end
      if (frame_tick) frames_dut++;
      if (ft_m(t)) frames_exp++;
      if (reset_n) rgb_in = 3'($urandom_range(0, 7));
   endtask

   initial begin
      reset_n = 1'b0;
      rgb_in  = 3'b000;
      repeat (3) step();

      // Release on a falling edge; the next rising edge is edge 1.
      reset_n = 1'b1;
      repeat (600) step();

      // Asynchronous reset in the middle of a clock period, deep in the frame.
      #2;
      reset_n   = 1'b0;
      rgb_in    = 3'b000;
      t         = 0;
      model_rgb = 3'b0;
      #1;
      check_state();
      repeat (3) step();

      reset_n    = 1'b1;
      frames_dut = 0;
      frames_exp = 0;
      phase2     = 1'b1;
      repeat (1900) step();

      chk("frames_vs_model", frames_dut, frames_exp);
      chk("frames_in_run",   frames_dut, 2);
      chk("hsync_low_clks",  hs_low,     HS * D);
      chk("vsync_low_clks",  vs_low,     VS * HT * D);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_vga_sync_gen
`default_nettype wire
